regbank_wr_ctrl: RTL
====================

Name: regbank_wr_ctrl

Overview:
- Write-port arbiter and sequencer for the 16x32 register bank.
- Shares the bank's single write port among two writeback requesters (A: ALU, B: load unit) and a link request that saves the PC into r15.
- Drives the bank's inpC/data/control lines and splits 32-bit immediate loads into two halfword writes (low half, then high half).

Parameters:
- IDLE_CTL, 3'b111, control code driven when no write is issued (bank no-op).
- LINK_REG, 4'hF, register index driven on rb_inpC during a link write.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A write request.
- a_rd  in  4  requester A destination register.
- a_data  in  32  requester A write data.
- a_mode  in  2  requester A mode: 00 full, 01 imm32 split, 10 low half only, 11 high half only.
- a_ack  out  1  one-cycle pulse when A's (final) write is issued.
- b_req, b_rd, b_data, b_mode, b_ack: same as A, for requester B.
- link_req  in  1  PC-save request.
- link_ack  out  1  one-cycle pulse when the link write is issued.
- rb_inpC  out  4  to bank inpC.
- rb_data  out  32  to bank data.
- rb_control  out  3  to bank control: 000 full, 001 low half, 010 high half, 011 PC to r15.
- busy  out  1  high while a split's high half is pending.
- stall_cnt  out  16  stall statistic (see Optional Feature).

Behaviour:
- Reset values (async, rst_n=0): rb_control=IDLE_CTL, rb_inpC=0, rb_data=0, all acks 0, busy=0, rr_ptr=A, stall_cnt=0, state=IDLE.
- All outputs are registered. A request sampled at posedge N drives rb_* and ack during cycle N..N+1. The bank commits at posedge N+1.
- States: IDLE/ISSUE (arbitrate every cycle) and SPLIT_HI.
- Priority at each arbitration posedge: link_req first, then round-robin between A and B.
  - rr_ptr points to the preferred requester and flips to the other after every A or B grant.
  - When only one of A/B requests, it wins regardless of rr_ptr.
- Link grant: rb_control=011, rb_inpC=LINK_REG, rb_data=0, link_ack=1.
- Grant with mode 00, 10 or 11: one cycle.
  - rb_control = 000, 001 or 010 respectively; rb_inpC=rd; rb_data=data.
  - ack=1 in the same cycle.
- Grant with mode 01 (split):
  - Cycle 1: rb_control=001, rb_data={16'h0, data[15:0]}, no ack, busy=1. The latched rd and data[31:16] are held.
  - Next posedge goes to SPLIT_HI with no arbitration. Cycle 2: rb_control=010, rb_data={data[31:16], 16'h0}, ack=1, busy=0.
  - A split is atomic: link_req cannot preempt it.
- No request at an arbitration posedge: rb_control=IDLE_CTL. rb_inpC and rb_data hold their last values.
- Handshake:
  - A requester holds req and its fields stable until its ack is seen.
  - A req sampled high while that requester's own ack is high counts as a new transaction.
  - A req deasserted before ack is dropped without a write.
- Same-rd conflict: A and B targeting the same rd are serialised in round-robin order. The later write wins in the bank.
- Reset mid-split: the low half may already be committed. The high half is not issued, no ack is given, and the FSM returns to IDLE.
- Throughput: 1 write/cycle; split = 2 cycles.

Optional Feature:
- Macro: REGBANK_WRCTRL_STALL_EN.
- Defined: stall_cnt increments by 1 at every posedge where at least one of a_req/b_req/link_req is sampled high and not granted. This includes cycles in SPLIT_HI. It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, then a_req with a_rd=3, a_data=32'h12345678, mode 00 -> next cycle rb_control=000, rb_inpC=3, rb_data=32'h12345678, a_ack=1 for exactly one cycle; r3 reads 32'h12345678.
- a_req and b_req held continuously with mode 00 (a_rd=1, b_rd=2) -> grants alternate A,B,A,B starting with A after reset; acks alternate; rb_control=000 every cycle.
- link_req together with a_req -> link first (rb_control=011, rb_inpC=4'hF, link_ack=1), A granted the following cycle; r15 equals pc.
- b_req mode 01, b_rd=5, b_data=32'hDEADBEEF, with link_req raised during cycle 1 -> 001/hBEEF then 010/hDEAD, busy=1 then 0, b_ack only in cycle 2, link granted in cycle 3; r5=32'hDEADBEEF.
- rst_n pulsed low during the first cycle of a split -> outputs reset immediately, no b_ack, rb_control=111 after release.
- REGBANK_WRCTRL_STALL_EN defined, a_req and b_req both held 4 cycles -> stall_cnt=4; force stall_cnt near 16'hFFFF -> it saturates. Undefined -> stall_cnt stays 0.

Source files
------------

// File: rtl/regbank_wr_ctrl.sv
// Write-port arbiter/sequencer for the 16x32 register bank (ALU, load, link).
// Optional stall statistic counter: define REGBANK_WRCTRL_STALL_EN.
module regbank_wr_ctrl #(
   parameter logic [2:0] IDLE_CTL = 3'b111,
   parameter logic [3:0] LINK_REG = 4'hF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic [3:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic [1:0]  a_mode,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [3:0]  b_rd,
   input  logic [31:0] b_data,
   input  logic [1:0]  b_mode,
   output logic        b_ack,
   input  logic        link_req,
   output logic        link_ack,
   output logic [3:0]  rb_inpC,
   output logic [31:0] rb_data,
   output logic [2:0]  rb_control,
   output logic        busy,
   output logic [15:0] stall_cnt
);

   typedef enum logic {S_IDLE, S_SPLIT_HI} state_t;

   state_t      state_q, state_d;
   logic        rr_ptr_q, rr_ptr_d;
   logic [3:0]  hi_rd_q, hi_rd_d;
   logic [15:0] hi_data_q, hi_data_d;
   logic        hi_who_q, hi_who_d;
   logic [3:0]  rb_inpC_q, rb_inpC_d;
   logic [31:0] rb_data_q, rb_data_d;
   logic [2:0]  rb_ctl_q, rb_ctl_d;
   logic        a_ack_q, a_ack_d;
   logic        b_ack_q, b_ack_d;
   logic        l_ack_q, l_ack_d;
   logic        busy_q, busy_d;

   logic        arb;
   logic        grant_link, grant_a, grant_b;
   logic [1:0]  sel_mode;
   logic [3:0]  sel_rd;
   logic [31:0] sel_data;

   // grant decode: link first, then round-robin between A and B
   always_comb begin
      arb        = (state_q == S_IDLE);
      grant_link = arb & link_req;
      grant_a    = arb & ~link_req & a_req & (~b_req | ~rr_ptr_q);
      grant_b    = arb & ~link_req & b_req & (~a_req | rr_ptr_q);
      sel_mode   = grant_b ? b_mode : a_mode;
      sel_rd     = grant_b ? b_rd   : a_rd;
      sel_data   = grant_b ? b_data : a_data;
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= 1'b0;
         hi_rd_q   <= '0;
         hi_data_q <= '0;
         hi_who_q  <= 1'b0;
         rb_inpC_q <= '0;
         rb_data_q <= '0;
         rb_ctl_q  <= IDLE_CTL;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         l_ack_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         hi_rd_q   <= hi_rd_d;
         hi_data_q <= hi_data_d;
         hi_who_q  <= hi_who_d;
         rb_inpC_q <= rb_inpC_d;
         rb_data_q <= rb_data_d;
         rb_ctl_q  <= rb_ctl_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         l_ack_q   <= l_ack_d;
         busy_q    <= busy_d;
      end
   end

   // next state: a split grant parks in SPLIT_HI for one cycle
   always_comb begin
      state_d   = S_IDLE;
      rr_ptr_d  = rr_ptr_q;
      hi_rd_d   = hi_rd_q;
      hi_data_d = hi_data_q;
      hi_who_d  = hi_who_q;
      if (grant_a | grant_b) begin
         rr_ptr_d = grant_a;
         if (sel_mode == 2'b01) begin
            state_d   = S_SPLIT_HI;
            hi_rd_d   = sel_rd;
            hi_data_d = sel_data[31:16];
            hi_who_d  = grant_b;
         end
      end
   end

   // next registered outputs toward the bank
   always_comb begin
      rb_ctl_d  = IDLE_CTL;
      rb_inpC_d = rb_inpC_q;
      rb_data_d = rb_data_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      l_ack_d   = 1'b0;
      busy_d    = 1'b0;
      unique case (1'b1)
         (state_q == S_SPLIT_HI): begin
            rb_ctl_d  = 3'b010;
            rb_inpC_d = hi_rd_q;
            rb_data_d = {hi_data_q, 16'h0};
            a_ack_d   = ~hi_who_q;
            b_ack_d   = hi_who_q;
         end
         grant_link: begin
            rb_ctl_d  = 3'b011;
            rb_inpC_d = LINK_REG;
            rb_data_d = '0;
            l_ack_d   = 1'b1;
         end
         (grant_a | grant_b): begin
            rb_inpC_d = sel_rd;
            rb_data_d = sel_data;
            a_ack_d   = grant_a;
            b_ack_d   = grant_b;
            unique case (sel_mode)
               2'b00: rb_ctl_d = 3'b000;
               2'b10: rb_ctl_d = 3'b001;
               2'b11: rb_ctl_d = 3'b010;
               default: begin
                  rb_ctl_d  = 3'b001;
                  rb_data_d = {16'h0, sel_data[15:0]};
                  a_ack_d   = 1'b0;
                  b_ack_d   = 1'b0;
                  busy_d    = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
   end

`ifdef REGBANK_WRCTRL_STALL_EN
   logic [15:0] stall_q, stall_d;
   logic        stalled;

   // saturating count of posedges where some requester waits
   always_comb begin
      stalled = (a_req & ~grant_a) | (b_req & ~grant_b)
              | (link_req & ~grant_link);
      stall_d = stall_q;
      if (stalled && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
   end

   // stall counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

   assign rb_inpC    = rb_inpC_q;
   assign rb_data    = rb_data_q;
   assign rb_control = rb_ctl_q;
   assign a_ack      = a_ack_q;
   assign b_ack      = b_ack_q;
   assign link_ack   = l_ack_q;
   assign busy       = busy_q;

endmodule
